// File: rtl/knn_point_fetch.sv
// Point-record fetch engine for a KNN core: reads {data, label} word pairs
// over a simple read-only master port and hands each point over with valid/ready.
module knn_point_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    n_points,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic [DATA_W-1:0]   pt_data,
  output logic [DATA_W-1:0]   pt_label,
  output logic                pt_last,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    pt_count
);

  typedef enum logic [2:0] {IDLE, RD_DATA, RD_LABEL, PUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [ADDR_W-1:0]   rec_addr_q, rec_addr_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic                pt_valid_q, pt_valid_d;
  logic [DATA_W-1:0]   pt_data_q, pt_data_d;
  logic [DATA_W-1:0]   pt_label_q, pt_label_d;
  logic                pt_last_q, pt_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    pt_count_q, pt_count_d;

  always_comb begin
    state_d    = state_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    rec_addr_d = rec_addr_q;
    n_d        = n_q;
    pt_valid_d = pt_valid_q;
    pt_data_d  = pt_data_q;
    pt_label_d = pt_label_q;
    pt_last_d  = pt_last_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pt_count_d = pt_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          pt_count_d = '0;
          n_d        = n_points;
          rec_addr_d = base_addr;
          if (n_points != '0) begin
            state_d   = RD_DATA;
            m_valid_d = 1'b1;
            m_addr_d  = base_addr;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RD_DATA: begin
        if (m_valid_q && m_ready) begin
          pt_data_d = m_rdata;
          m_valid_d = 1'b0;
          m_addr_d  = rec_addr_q + ADDR_W'(4);
          state_d   = RD_LABEL;
        end
      end
      RD_LABEL: begin
        // Entry cycle leaves m_valid low so requests are never back-to-back.
        if (!m_valid_q) begin
          m_valid_d = 1'b1;
        end else if (m_ready) begin
          pt_label_d = m_rdata;
          m_valid_d  = 1'b0;
          pt_valid_d = 1'b1;
          pt_last_d  = (pt_count_q == n_q - CNT_W'(1));
          state_d    = PUSH;
        end
      end
      PUSH: begin
        if (pt_ready) begin
          pt_valid_d = 1'b0;
          pt_last_d  = 1'b0;
          pt_count_d = pt_count_q + CNT_W'(1);
          if (pt_last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rec_addr_d = rec_addr_q + ADDR_W'(8);
            m_addr_d   = rec_addr_q + ADDR_W'(8);
            m_valid_d  = 1'b1;
            state_d    = RD_DATA;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      rec_addr_q <= '0;
      n_q        <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q  <= '0;
      pt_label_q <= '0;
      pt_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pt_count_q <= '0;
    end else begin
      state_q    <= state_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      rec_addr_q <= rec_addr_d;
      n_q        <= n_d;
      pt_valid_q <= pt_valid_d;
      pt_data_q  <= pt_data_d;
      pt_label_q <= pt_label_d;
      pt_last_q  <= pt_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pt_count_q <= pt_count_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = '0;
  assign m_wstrb  = '0;
  assign pt_valid = pt_valid_q;
  assign pt_data  = pt_data_q;
  assign pt_label = pt_label_q;
  assign pt_last  = pt_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pt_count = pt_count_q;

endmodule

// File: doc/knn_point_fetch.md
KNN_POINT_FETCH -- requirements
Module: knn_point_fetch

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 32, byte-address width of the native master port.
REQ-002 The block SHALL have parameter DATA_W, default 32, data word width.
REQ-003 The block SHALL have parameter CNT_W, default 16, width of the point counter.

Ports:
REQ-004 The block SHALL have clk, input, 1, the single clock.
REQ-005 The block SHALL have rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have start, input, 1, one-cycle request to begin a fetch run.
REQ-007 The block SHALL have base_addr, input, ADDR_W, byte address of the first point record, sampled on start.
REQ-008 The block SHALL have n_points, input, CNT_W, number of points to fetch, sampled on start.
REQ-009 The block SHALL have m_valid, output, 1, native master request valid.
REQ-010 The block SHALL have m_addr, output, ADDR_W, native master byte address.
REQ-011 The block SHALL have m_wdata, output, DATA_W, tied to 0.
REQ-012 The block SHALL have m_wstrb, output, DATA_W/8, tied to 0 (read-only master).
REQ-013 The block SHALL have m_rdata, input, DATA_W, read data, valid when m_ready=1.
REQ-014 The block SHALL have m_ready, input, 1, one-cycle completion of the current request.
REQ-015 The block SHALL have pt_valid, output, 1, a fetched point is presented to the KNN core.
REQ-016 The block SHALL have pt_ready, input, 1, the KNN core accepts the point.
REQ-017 The block SHALL have pt_data, output, DATA_W, point coordinate word.
REQ-018 The block SHALL have pt_label, output, DATA_W, point label word.
REQ-019 The block SHALL have pt_last, output, 1, marks the final point of the run.
REQ-020 The block SHALL have busy, output, 1, high from accepted start until DONE exits.
REQ-021 The block SHALL have done, output, 1, one-cycle pulse at run end.
REQ-022 The block SHALL have pt_count, output, CNT_W, points handed over in current/last run.

Function
REQ-023 Record layout SHALL be two words per point: data at base_addr+8*i, label at base_addr+8*i+4; address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-024 The FSM SHALL have states IDLE, RD_DATA, RD_LABEL, PUSH, DONE.
REQ-025 IDLE: on start with n_points!=0 -> RD_DATA next cycle, latch base_addr/n_points, clear pt_count; on start with n_points=0 -> DONE, no bus access.
REQ-026 RD_DATA/RD_LABEL SHALL assert m_valid with a stable m_addr until the cycle m_ready=1; m_rdata SHALL be captured into pt_data/pt_label on that cycle.
REQ-027 m_valid SHALL drop for at least the cycle after each m_ready (no back-to-back requests); RD_DATA -> RD_LABEL -> PUSH on m_ready.
REQ-028 PUSH SHALL hold pt_valid, pt_data, pt_label, pt_last stable until pt_ready=1; on acceptance pt_count increments, then -> RD_DATA if points remain, else DONE.
REQ-029 pt_last SHALL be 1 only while presenting point index n_points-1.
REQ-030 DONE SHALL assert done for exactly one cycle and return to IDLE; busy SHALL fall in the same transition.
REQ-031 start while busy SHALL be ignored.
REQ-032 Latency: start to first m_valid SHALL be 1 cycle; m_ready(label) to pt_valid SHALL be 1 cycle; final pt_ready to done SHALL be 1 cycle.
REQ-033 m_valid and pt_valid SHALL never be high simultaneously.

Reset
REQ-034 rst SHALL asynchronously force IDLE and m_valid=0, m_addr=0, pt_valid=0, pt_data=0, pt_label=0, pt_last=0, busy=0, done=0, pt_count=0.
REQ-035 rst mid-run SHALL abandon the run with no done pulse; a late m_ready after reset SHALL be ignored.

Verification
REQ-036 start, base_addr=0x1000, n_points=2, m_ready after 1 cycle, pt_ready=1 -> m_addr sequence 0x1000,0x1004,0x1008,0x100C; two points; pt_last on second; done once; pt_count=2.
REQ-037 n_points=0 -> done one cycle after start, m_valid never asserted, pt_count=0.
REQ-038 pt_ready held 0 for 5 cycles in PUSH -> pt_valid/pt_data/pt_label stable, no new m_valid, pt_count unchanged.
REQ-039 m_ready delayed 4 cycles -> m_valid and m_addr held stable for all 4 cycles.
REQ-040 base_addr=0xFFFFFFF8, n_points=2 -> second point addresses 0x00000000, 0x00000004.
REQ-041 rst pulsed in RD_LABEL, second start issued while busy -> outputs at reset values, no done; busy-time start ignored.
